lockin_period_demod: RTL and testbench

//  Downstream consumer of the modulation generator. Multiplies the error-signal sample by the in-phase
//  (cos_ref) and quadrature (sin_ref) references, integrates over 2^nper whole modulation periods delimited
//  by harmonic_trig, then dumps scaled, saturated X/Y results with a one-cycle valid strobe. Feeds the PID
//  and the register bank.

---
 rtl/lockin_pkg.sv | 30 +++
 rtl/lockin_shift_sat.sv | 31 +++
 rtl/lockin_period_demod.sv | 270 +++++++++++++++++++++++++++
 tb/tb_lockin_period_demod.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lockin_pkg.sv
// Shared definitions for the lock-in period demodulator: default widths,
// the controller state type and helpers for the output saturation limits.
// Optional feature macro used by the top level: LOCKIN_SQ_DEMOD_EN.
package lockin_pkg;

   localparam int DW_DEF    = 14;
   localparam int ACC_W_DEF = 64;
   localparam int OW_DEF    = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      INTEG = 2'd2
   } state_t;

   // Largest positive value representable in an ow-bit signed result
   function automatic logic signed [127:0] sat_hi(input int ow);
      return (128'sd1 <<< (ow - 1)) - 128'sd1;
   endfunction

   // Most negative value representable in an ow-bit signed result
   function automatic logic signed [127:0] sat_lo(input int ow);
      return -(128'sd1 <<< (ow - 1));
   endfunction

   // Saturation limits for the default output width
   localparam logic signed [ACC_W_DEF-1:0] OUT_MAX_DEF = ACC_W_DEF'(sat_hi(OW_DEF));
   localparam logic signed [ACC_W_DEF-1:0] OUT_MIN_DEF = ACC_W_DEF'(sat_lo(OW_DEF));

endpackage

// File: rtl/lockin_shift_sat.sv
// Combinational arithmetic right shift of a wide accumulator followed by
// saturation into the narrower signed output range.
module lockin_shift_sat
   import lockin_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int OW    = OW_DEF
) (
   input  logic signed [ACC_W-1:0] acc,
   input  logic        [5:0]       shift,
   output logic signed [OW-1:0]    res
);

   localparam logic signed [ACC_W-1:0] HI = ACC_W'(sat_hi(OW));
   localparam logic signed [ACC_W-1:0] LO = ACC_W'(sat_lo(OW));

   logic signed [ACC_W-1:0] shifted;

   // Shift first, then clamp anything that does not fit the output width
   always_comb begin
      shifted = acc >>> shift;
      if (shifted > HI) begin
         res = HI[OW-1:0];
      end else if (shifted < LO) begin
         res = LO[OW-1:0];
      end else begin
         res = shifted[OW-1:0];
      end
   end

endmodule

// File: rtl/lockin_period_demod.sv
// Lock-in demodulator: multiplies the error sample by the in-phase and
// quadrature references, integrates over 2^nper modulation periods and
// dumps shifted, saturated X/Y results with a one-cycle valid strobe.
// Optional square-wave demodulation is enabled by LOCKIN_SQ_DEMOD_EN.
module lockin_period_demod
   import lockin_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int ACC_W = ACC_W_DEF,
   parameter int OW    = OW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [DW-1:0] in_sig,
   input  logic [DW-1:0] sin_ref,
   input  logic [DW-1:0] cos_ref,
   input  logic          harm_trig,
   input  logic [3:0]    nper,
   input  logic [5:0]    shift,
`ifdef LOCKIN_SQ_DEMOD_EN
   input  logic          sq_mode,
   input  logic          sq_ref,
   input  logic          sq_quad,
   input  logic          sq_trig,
`endif
   output logic [OW-1:0] x_out,
   output logic [OW-1:0] y_out,
   output logic [31:0]   n_smp,
   output logic          out_valid,
   output logic          busy
);

   localparam int PW = 2 * DW;

   state_t state;
   state_t state_nxt;

   logic signed [DW-1:0]    sel_sin;
   logic signed [DW-1:0]    sel_cos;
   logic                    sel_trig;

   logic signed [DW-1:0]    s1_in;
   logic signed [DW-1:0]    s1_sin;
   logic signed [DW-1:0]    s1_cos;
   logic                    s1_trig;

   logic signed [PW-1:0]    p_x;
   logic signed [PW-1:0]    p_y;
   logic                    s2_trig;

   logic signed [ACC_W-1:0] acc_x;
   logic signed [ACC_W-1:0] acc_y;
   logic signed [ACC_W-1:0] sum_x;
   logic signed [ACC_W-1:0] sum_y;
   logic [31:0]             smp_cnt;
   logic [31:0]             smp_inc;
   logic [16:0]             per_cnt;
   logic [16:0]             per_target;
   logic                    last_period;
   logic [3:0]              nper_lat;
   logic [5:0]              shift_lat;

   logic                    win_start;
   logic                    win_end;
   logic                    keep_integ;

   logic signed [ACC_W-1:0] dump_x;
   logic signed [ACC_W-1:0] dump_y;
   logic [31:0]             dump_n;
   logic [5:0]              dump_shift;
   logic                    dump_valid;

   logic signed [OW-1:0]    sat_x;
   logic signed [OW-1:0]    sat_y;

`ifdef LOCKIN_SQ_DEMOD_EN
   localparam logic signed [DW-1:0] SQ_POS = DW'((1 << (DW - 1)) - 1);
   localparam logic signed [DW-1:0] SQ_NEG = -SQ_POS;

   logic mode_reg;
   logic mode_act;

   // Square mode is only picked up while not integrating; INTEG runs on the held copy
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_reg <= 1'b0;
      end else if (state != INTEG) begin
         mode_reg <= sq_mode;
      end
   end
`endif

   // Choose the reference pair and period boundary for the active demodulation mode
   always_comb begin
      sel_sin  = sin_ref;
      sel_cos  = cos_ref;
      sel_trig = harm_trig;
`ifdef LOCKIN_SQ_DEMOD_EN
      mode_act = (state == INTEG) ? mode_reg : sq_mode;
      if (mode_act) begin
         sel_cos  = sq_ref  ? SQ_POS : SQ_NEG;
         sel_sin  = sq_quad ? SQ_POS : SQ_NEG;
         sel_trig = sq_trig;
      end
`endif
   end

   // S1 input registers and S2 full-precision product registers
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_in   <= '0;
         s1_sin  <= '0;
         s1_cos  <= '0;
         s1_trig <= 1'b0;
         p_x     <= '0;
         p_y     <= '0;
         s2_trig <= 1'b0;
      end else begin
         s1_in   <= in_sig;
         s1_sin  <= sel_sin;
         s1_cos  <= sel_cos;
         s1_trig <= sel_trig;
         p_x     <= s1_in * s1_cos;
         p_y     <= s1_in * s1_sin;
         s2_trig <= s1_trig;
      end
   end

   // The trigger-cycle product belongs to the window it closes, so sums include p
   assign sum_x       = acc_x + {{(ACC_W - PW){p_x[PW-1]}}, p_x};
   assign sum_y       = acc_y + {{(ACC_W - PW){p_y[PW-1]}}, p_y};
   assign smp_inc     = (smp_cnt == 32'hFFFF_FFFF) ? smp_cnt : smp_cnt + 32'd1;
   assign per_target  = 17'd1 << nper_lat;
   assign last_period = (per_cnt + 17'd1) == per_target;
   assign busy        = (state == ARM) || (state == INTEG);
   assign keep_integ  = (state == INTEG) && (state_nxt == INTEG);

   // Controller state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; dropping en always wins and discards the open window
   always_comb begin
      state_nxt = state;
      win_start = 1'b0;
      win_end   = 1'b0;
      case (state)
         IDLE: begin
            if (en) begin
               state_nxt = ARM;
            end
         end
         ARM: begin
            if (s2_trig) begin
               state_nxt = INTEG;
               win_start = 1'b1;
            end
         end
         INTEG: begin
            if (s2_trig && last_period) begin
               win_end = 1'b1;
            end
`ifdef LOCKIN_SQ_DEMOD_EN
            if (sq_mode != mode_reg) begin
               state_nxt = ARM;
               win_end   = 1'b0;
            end
`endif
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      if (!en) begin
         state_nxt = IDLE;
         win_start = 1'b0;
         win_end   = 1'b0;
      end
   end

   // Accumulate, count samples/periods and capture the window sums at each window end
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_x      <= '0;
         acc_y      <= '0;
         smp_cnt    <= '0;
         per_cnt    <= '0;
         nper_lat   <= '0;
         shift_lat  <= '0;
         dump_x     <= '0;
         dump_y     <= '0;
         dump_n     <= '0;
         dump_shift <= '0;
         dump_valid <= 1'b0;
      end else begin
         dump_valid <= 1'b0;
         if (win_start) begin
            acc_x     <= '0;
            acc_y     <= '0;
            smp_cnt   <= '0;
            per_cnt   <= '0;
            nper_lat  <= nper;
            shift_lat <= shift;
         end else if (keep_integ) begin
            if (win_end) begin
               dump_x     <= sum_x;
               dump_y     <= sum_y;
               dump_n     <= smp_inc;
               dump_shift <= shift_lat;
               dump_valid <= 1'b1;
               acc_x      <= '0;
               acc_y      <= '0;
               smp_cnt    <= '0;
               per_cnt    <= '0;
               nper_lat   <= nper;
               shift_lat  <= shift;
            end else begin
               acc_x   <= sum_x;
               acc_y   <= sum_y;
               smp_cnt <= smp_inc;
               if (s2_trig) begin
                  per_cnt <= per_cnt + 17'd1;
               end
            end
         end
      end
   end

   lockin_shift_sat #(
      .ACC_W (ACC_W),
      .OW    (OW)
   ) u_sat_x (
      .acc   (dump_x),
      .shift (dump_shift),
      .res   (sat_x)
   );

   lockin_shift_sat #(
      .ACC_W (ACC_W),
      .OW    (OW)
   ) u_sat_y (
      .acc   (dump_y),
      .shift (dump_shift),
      .res   (sat_y)
   );

   // Registered outputs; they hold their value between dumps
   always_ff @(posedge clk) begin
      if (rst) begin
         x_out     <= '0;
         y_out     <= '0;
         n_smp     <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= dump_valid;
         if (dump_valid) begin
            x_out <= sat_x;
            y_out <= sat_y;
            n_smp <= dump_n;
         end
      end
   end

endmodule

// File: tb/tb_lockin_period_demod.sv
// Self-checking bench for lockin_period_demod: a window-level reference model
// pushes expected dumps into a scoreboard queue, a monitor pops and compares.
module tb_lockin_period_demod;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [13:0] in_sig;
   logic [13:0] sin_ref;
   logic [13:0] cos_ref;
   logic        harm_trig;
   logic [3:0]  nper;
   logic [5:0]  shift;
   logic [31:0] x_out;
   logic [31:0] y_out;
   logic [31:0] n_smp;
   logic        out_valid;
   logic        busy;
`ifdef LOCKIN_SQ_DEMOD_EN
   logic        sq_mode = 1'b0;
   logic        sq_ref  = 1'b0;
   logic        sq_quad = 1'b0;
   logic        sq_trig = 1'b0;
`endif

   lockin_period_demod dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_sig    (in_sig),
      .sin_ref   (sin_ref),
      .cos_ref   (cos_ref),
      .harm_trig (harm_trig),
      .nper      (nper),
      .shift     (shift),
`ifdef LOCKIN_SQ_DEMOD_EN
      .sq_mode   (sq_mode),
      .sq_ref    (sq_ref),
      .sq_quad   (sq_quad),
      .sq_trig   (sq_trig),
`endif
      .x_out     (x_out),
      .y_out     (y_out),
      .n_smp     (n_smp),
      .out_valid (out_valid),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int in_v;
      int sin_v;
      int cos_v;
      bit trig;
   } smp_t;

   typedef struct {
      longint x;
      longint y;
      longint n;
      int     due;
   } exp_t;

   int   err_cnt = 0;
   int   chk_cnt = 0;
   int   edge_no = 0;
   exp_t sb_q[$];
   exp_t mon_e;

   int   cur_in = 0;
   int   cur_sin = 0;
   int   cur_cos = 0;
   bit   cur_trig = 1'b0;
   bit   rand_data = 1'b0;
   int   trig_period = 100;
   int   trig_cnt = 0;

   // Reference model: samples reach the integrator two clocks after the inputs
   smp_t   d1 = '{0, 0, 0, 1'b0};
   smp_t   d2 = '{0, 0, 0, 1'b0};
   bit     m_enabled = 1'b0;
   bit     m_in_window = 1'b0;
   longint m_sum_x = 0;
   longint m_sum_y = 0;
   longint m_n = 0;
   int     m_periods_left = 0;
   int     m_shift = 0;

   always @(posedge clk) edge_no <= edge_no + 1;

   task automatic check_output(input string name, input longint act, input longint exp_v);
      chk_cnt++;
      if (act !== exp_v) begin
         err_cnt++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp_v);
      end
   endtask

   function automatic longint scale_sat(input longint v, input int sh);
      longint s;
      s = v >>> sh;
      if (s > 64'sd2147483647) return 64'sd2147483647;
      if (s < -64'sd2147483648) return -64'sd2147483648;
      return s;
   endfunction

   function automatic void open_window();
      m_in_window    = 1'b1;
      m_sum_x        = 0;
      m_sum_y        = 0;
      m_n            = 0;
      m_periods_left = 1 << int'(nper);
      m_shift        = int'(shift);
   endfunction

   function automatic void model_step();
      smp_t al;
      exp_t e;
      al = d2;
      d2 = d1;
      d1 = '{cur_in, cur_sin, cur_cos, cur_trig};
      if (rst) begin
         d1 = '{0, 0, 0, 1'b0};
         d2 = '{0, 0, 0, 1'b0};
         m_enabled   = 1'b0;
         m_in_window = 1'b0;
         sb_q.delete();
      end else if (!en) begin
         m_enabled   = 1'b0;
         m_in_window = 1'b0;
      end else if (!m_enabled) begin
         m_enabled = 1'b1;
      end else if (!m_in_window) begin
         if (al.trig) open_window();
      end else begin
         m_sum_x += longint'(al.in_v) * longint'(al.cos_v);
         m_sum_y += longint'(al.in_v) * longint'(al.sin_v);
         m_n++;
         if (al.trig) begin
            m_periods_left--;
            if (m_periods_left == 0) begin
               e.x   = scale_sat(m_sum_x, m_shift);
               e.y   = scale_sat(m_sum_y, m_shift);
               e.n   = m_n;
               e.due = edge_no + 2;
               sb_q.push_back(e);
               open_window();
            end
         end
      end
   endfunction

   task automatic apply_stimulus(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (rand_data) begin
            cur_in  = int'($urandom_range(0, 16383)) - 8192;
            cur_cos = int'($urandom_range(0, 16383)) - 8192;
            cur_sin = int'($urandom_range(0, 16383)) - 8192;
         end
         cur_trig  = (trig_cnt >= trig_period - 1);
         trig_cnt  = cur_trig ? 0 : trig_cnt + 1;
         in_sig    = 14'(cur_in);
         cos_ref   = 14'(cur_cos);
         sin_ref   = 14'(cur_sin);
         harm_trig = cur_trig;
         @(posedge clk);
         model_step();
         #1;
         check_output("busy", longint'(busy), longint'(m_enabled));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_output({tag, "_x"}, longint'($signed(x_out)), 0);
      check_output({tag, "_y"}, longint'($signed(y_out)), 0);
      check_output({tag, "_n"}, longint'(n_smp), 0);
      check_output({tag, "_valid"}, longint'(out_valid), 0);
      check_output({tag, "_busy"}, longint'(busy), 0);
   endtask

   // Monitor: every strobe must match the oldest expected dump, on its due edge
   always @(posedge clk) begin
      #1;
      if (out_valid) begin
         if (sb_q.size() == 0) begin
            chk_cnt++;
            err_cnt++;
            $display("[TB] FAIL spurious_valid: got out_valid=1 expected 0 at edge %0d", edge_no);
         end else begin
            mon_e = sb_q.pop_front();
            check_output("dump_edge", longint'(edge_no), longint'(mon_e.due));
            check_output("x_out", longint'($signed(x_out)), mon_e.x);
            check_output("y_out", longint'($signed(y_out)), mon_e.y);
            check_output("n_smp", longint'(n_smp), mon_e.n);
         end
      end else if (sb_q.size() > 0 && sb_q[0].due < edge_no) begin
         chk_cnt++;
         err_cnt++;
         $display("[TB] FAIL missed_valid: got no strobe expected one at edge %0d", sb_q[0].due);
         void'(sb_q.pop_front());
      end
   end

   initial begin
      rst = 1'b1;
      en = 1'b0;
      in_sig = '0;
      sin_ref = '0;
      cos_ref = '0;
      harm_trig = 1'b0;
      nper = 4'd0;
      shift = 6'd0;
      apply_stimulus(3);
      rst = 1'b0;
      check_reset_outputs("reset");

      $display("[TB] constant in-phase input, one period per window");
      en = 1'b1;
      cur_in = 1000;
      cur_cos = 8191;
      cur_sin = 0;
      trig_period = 100;
      trig_cnt = 0;
      apply_stimulus(450);
      check_output("t1_x", longint'($signed(x_out)), 819100000);
      check_output("t1_y", longint'($signed(y_out)), 0);
      check_output("t1_n", longint'(n_smp), 100);

      $display("[TB] four periods per window, saturating then shifted");
      nper = 4'd2;
      apply_stimulus(1700);
      check_output("t2_x_sat", longint'($signed(x_out)), 2147483647);
      check_output("t2_n", longint'(n_smp), 400);
      shift = 6'd2;
      apply_stimulus(1700);
      check_output("t2_x_shift", longint'($signed(x_out)), 819100000);

      $display("[TB] full-scale negative operands");
      cur_in = -8192;
      cur_cos = -8192;
      trig_period = 50;
      trig_cnt = 0;
      shift = 6'd4;
      nper = 4'd0;
      apply_stimulus(500);
      check_output("t3_x", longint'($signed(x_out)), 209715200);
      check_output("t3_n", longint'(n_smp), 50);

      $display("[TB] random data with a one-cycle enable drop");
      rand_data = 1'b1;
      trig_period = 37;
      trig_cnt = 0;
      nper = 4'd1;
      shift = 6'd3;
      apply_stimulus(300);
      en = 1'b0;
      apply_stimulus(1);
      en = 1'b1;
      apply_stimulus(400);

      $display("[TB] back-to-back triggers");
      trig_period = 1;
      nper = 4'd2;
      shift = 6'd0;
      apply_stimulus(40);
      trig_period = 2;
      trig_cnt = 0;
      apply_stimulus(40);

      $display("[TB] reset mid-window and nper change mid-window");
      trig_period = 64;
      trig_cnt = 0;
      nper = 4'd1;
      shift = 6'd6;
      apply_stimulus(250);
      rst = 1'b1;
      apply_stimulus(1);
      rst = 1'b0;
      check_reset_outputs("mid_reset");
      apply_stimulus(150);
      nper = 4'd0;
      apply_stimulus(100);
      nper = 4'd2;
      apply_stimulus(600);

      $display("[TB] randomized configurations");
      for (int k = 0; k < 4; k++) begin
         trig_period = int'($urandom_range(10, 40));
         trig_cnt = 0;
         nper = 4'($urandom_range(0, 2));
         shift = 6'($urandom_range(0, 40));
         apply_stimulus(300);
      end

      en = 1'b0;
      apply_stimulus(10);
      check_output("pending_dumps", longint'(sb_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
